// File: rtl/fft_frame_tx.sv
// fft_frame_tx -- AXI4-Stream frame transmitter for the FFT data input.
//
// Free-running ADC samples (strobe only, no backpressure) are collected into
// an on-chip frame buffer. Each completed frame is replayed as an AXIS burst
// with tlast on the final beat. The frame length is 2^curr_nfft, captured when
// the first sample of a frame is written. Illegal values fall back to
// 2^MAX_LOG2.
//
// Build option:
//   FFT_TX_PINGPONG_EN  two buffer banks. Filling continues into the
//                       alternate bank while the other one is sent. Without it
//                       there is a single bank, and samples arriving while the
//                       bank is being sent are dropped.
//
// Ports:
//   clk, rstn        clock; asynchronous active-low reset
//   curr_nfft        frame log2 (legal MIN_LOG2..MAX_LOG2)
//   sample_in        signed ADC sample
//   sample_valid     one-cycle strobe per sample
//   m_axis_tdata     {16'd0, sign-extended sample to 16 bits}
//   m_axis_tvalid    AXIS valid
//   m_axis_tready    AXIS ready
//   m_axis_tlast     final beat of a frame
//   frame_sent       pulse coincident with the tlast handshake
//   drop_cnt         saturating count of discarded samples
//   busy             a frame is queued or being sent
module fft_frame_tx #(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned MAX_LOG2 = 10,
  parameter int unsigned MIN_LOG2 = 7
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [4:0]          curr_nfft,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic [31:0]         m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                frame_sent,
  output logic [15:0]         drop_cnt,
  output logic                busy
);

`ifdef FFT_TX_PINGPONG_EN
  localparam logic        PP = 1'b1;
  localparam int unsigned AW = MAX_LOG2 + 1;
`else
  localparam logic        PP = 1'b0;
  localparam int unsigned AW = MAX_LOG2;
`endif

  typedef logic [MAX_LOG2-1:0] ptr_t;
  typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

  localparam ptr_t ONE = ptr_t'(1);

  logic [SAMPLE_W-1:0] mem [1 << AW];

  ptr_t      wr_ptr, wr_mask, cur_mask, new_mask, rd_ptr, rd_mask;
  ptr_t      len_q  [2];
  logic      full_q [2];   // bank written and not yet fully sent
  logic      pend_q [2];   // bank written and not yet started by the reader
  logic      wb, ib, cb;   // write bank, read-issue bank, completing bank
  logic [4:0] l_eff;
  logic      wr_ok, wr_last;
  rd_state_t state, state_nx;
  logic      can_issue, issue, issue_last, start;
  logic      s1_vld, s1_last, s1_adv, hs, last_hs;
  logic [SAMPLE_W-1:0] s1_data;
  logic [AW-1:0] wa, ra;

`ifdef FFT_TX_PINGPONG_EN
  assign wa = {wb, wr_ptr};
  assign ra = {ib, rd_ptr};
`else
  assign wa = wr_ptr;
  assign ra = rd_ptr;
`endif

  assign frame_sent = last_hs;
  assign busy       = full_q[0] | full_q[1];

  always_comb begin
    l_eff = curr_nfft;
    if (curr_nfft < 5'(MIN_LOG2) || curr_nfft > 5'(MAX_LOG2)) l_eff = 5'(MAX_LOG2);
    new_mask = ptr_t'((32'd1 << l_eff) - 32'd1);
    // Length is sampled only on the first write of a frame.
    cur_mask = (wr_ptr == '0) ? new_mask : wr_mask;
    wr_ok    = sample_valid && !full_q[wb];
    wr_last  = wr_ok && (wr_ptr == cur_mask);
  end

  // Reader: memory read (stage 1) feeds the prefetching output register.
  // Stage 1 refills whenever it is empty or moving into the output register,
  // so with tready high one beat leaves per clock. Leaving RD_IDLE issues in
  // the same cycle, which lets a queued bank follow the previous tlast
  // without a bubble.
  always_comb begin
    hs         = m_axis_tvalid && m_axis_tready;
    last_hs    = hs && m_axis_tlast;
    s1_adv     = s1_vld && (!m_axis_tvalid || m_axis_tready);
    can_issue  = !s1_vld || s1_adv;
    state_nx   = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    start      = 1'b0;
    case (state)
      RD_IDLE: begin
        if (pend_q[ib] && can_issue) begin
          issue    = 1'b1;
          start    = 1'b1;
          state_nx = RD_RUN;
        end
      end
      RD_RUN: begin
        if (can_issue) begin
          issue = 1'b1;
          if (rd_ptr == rd_mask) begin
            issue_last = 1'b1;
            state_nx   = RD_IDLE;
          end
        end
      end
      default: state_nx = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= RD_IDLE;
      wr_ptr        <= '0;
      wr_mask       <= '0;
      rd_ptr        <= '0;
      rd_mask       <= '0;
      wb            <= 1'b0;
      ib            <= 1'b0;
      cb            <= 1'b0;
      full_q        <= '{default: 1'b0};
      pend_q        <= '{default: 1'b0};
      len_q         <= '{default: '0};
      s1_vld        <= 1'b0;
      s1_last       <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      state <= state_nx;

      if (wr_ok) begin
        if (wr_ptr == '0) wr_mask <= new_mask;
        if (wr_last) begin
          wr_ptr     <= '0;
          full_q[wb] <= 1'b1;
          pend_q[wb] <= 1'b1;
          len_q[wb]  <= cur_mask;
          wb         <= wb ^ PP;
        end else begin
          wr_ptr <= wr_ptr + ONE;
        end
      end else if (sample_valid && drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 16'd1;
      end

      if (start) begin
        pend_q[ib] <= 1'b0;
        rd_mask    <= len_q[ib];
      end
      if (issue) rd_ptr <= issue_last ? '0 : rd_ptr + ONE;
      if (issue_last) ib <= ib ^ PP;

      if (issue) begin
        s1_vld  <= 1'b1;
        s1_last <= issue_last;
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end

      if (s1_adv) begin
        m_axis_tdata  <= {16'd0, {(16 - SAMPLE_W){s1_data[SAMPLE_W-1]}}, s1_data};
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= s1_last;
      end else if (hs) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      if (last_hs) begin
        full_q[cb] <= 1'b0;
        cb         <= cb ^ PP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wa] <= sample_in;
    if (issue) s1_data <= mem[ra];
  end

endmodule

// File: doc/fft_frame_tx.md
Name: fft_frame_tx

Overview:
- AXI4-Stream transmitter feeding the FFT data input. It is the sending counterpart of the FFT-output receivers.
- Collects free-running ADC samples (valid only, no backpressure) into an on-chip frame buffer of curr_nfft-selected length.
- Replays each completed frame as an AXIS burst with tvalid/tready/tlast.
- Replaces the FIFO-threshold plus separate tlast generator arrangement on the FFT input side.

Parameters:
- SAMPLE_W, 12, width of the signed ADC sample.
- MAX_LOG2, 10, log2 of the largest frame, and therefore the buffer depth (2^MAX_LOG2 words per bank).
- MIN_LOG2, 7, smallest legal frame log2.

Ports:
- clk  input  1  system clock (FFT clock domain).
- rstn  input  1  asynchronous active-low reset.
- curr_nfft  input  5  frame log2 from the config manager. Legal range MIN_LOG2..MAX_LOG2.
- sample_in  input  SAMPLE_W  signed sample, already in this clock domain.
- sample_valid  input  1  one-cycle strobe per sample. No backpressure to the source.
- m_axis_tdata  output  32  {16'd0, 4×sign, sample}; the sign is replicated up to bit 15.
- m_axis_tvalid  output  1  AXIS valid.
- m_axis_tready  input  1  AXIS ready from the FFT.
- m_axis_tlast  output  1  high on the final beat of a frame.
- frame_sent  output  1  one-cycle pulse on the tlast handshake.
- drop_cnt  output  16  saturating count of samples discarded.
- busy  output  1  high in SEND.

Behaviour:
- Reset: async, active-low. All outputs go to 0 and the state goes to FILL with wr_ptr=0. Buffer contents are don't-care. Reset mid-frame abandons the frame; no tlast is emitted afterwards.
- Frame length N:
  - N = 2^L, where L = curr_nfft latched when wr_ptr=0 and the first sample of a frame is written.
  - Illegal curr_nfft (<MIN_LOG2 or >MAX_LOG2) is treated as MAX_LOG2.
  - curr_nfft changes mid-frame take effect only at the next frame start.
- State FILL:
  - Each sample_valid writes mem[wr_ptr] and increments wr_ptr.
  - A write with wr_ptr=N-1 moves the block to SEND on the same edge.
  - m_axis_tvalid stays 0 throughout FILL.
- State SEND:
  - rd_ptr starts at 0. The buffer read has 1-cycle latency and the output register is a prefetching stage.
  - m_axis_tvalid rises exactly 2 clocks after the edge that wrote sample N-1.
  - With tready held high, one beat is sent per clock, N beats back to back.
  - While tvalid=1 and tready=0, tdata and tlast are held stable, and tvalid never deasserts before a handshake.
  - tlast=1 only on beat N-1, i.e. the beat carrying sample index N-1.
  - On the tlast handshake: frame_sent pulses, tvalid drops the next cycle (unless another frame is ready), wr_ptr=0, and the state returns to FILL.
- Sample order out equals arrival order; sample 0 is the first beat.
- Drops (single-bank build):
  - Any sample_valid while in SEND is discarded and increments drop_cnt.
  - drop_cnt saturates at 16'hFFFF and clears only on reset.
- Simultaneous sample_valid on the tlast handshake cycle: the sample is dropped (single-bank build).
- Sign extension: tdata[15:SAMPLE_W] = sample_in[SAMPLE_W-1]; tdata[31:16] = 0.

Optional Feature:
- FFT_TX_PINGPONG_EN defined:
  - Two banks of 2^MAX_LOG2 words.
  - Filling continues into the alternate bank while the other bank is sent.
  - A bank filled while the other is still sending is queued. Its first beat follows the previous tlast beat with no gap when tready stays high.
  - Drops occur only when both banks are full or pending, i.e. a sample arrives while a filled bank waits and the other bank is sending.
  - busy means any bank is pending or sending.
- Undefined: single bank, with FILL/SEND exclusive as described above.

Test Plan:
1. Basic frame: curr_nfft=7, ramp samples 0..127 at 1 per 4 clocks, tready=1.
   - tvalid rises 2 clocks after the write of sample 127.
   - 128 consecutive beats with tdata[11:0]=0..127.
   - tlast only on beat 127; frame_sent pulses once; drop_cnt=0.
2. Sign and format: samples 12'h800 and 12'h7FF.
   - tdata is 32'h0000F800 and 32'h000007FF respectively.
3. Backpressure: curr_nfft=8, tready toggling pseudo-randomly.
   - All 256 beats arrive in order; tdata and tlast are stable while stalled; exactly one tlast.
4. Drops (single-bank): curr_nfft=7, sample_valid every clock, tready=0 for 50 clocks in SEND.
   - drop_cnt increments by 1 per SEND-cycle strobe.
   - The next frame starts with the first sample after the tlast handshake.
5. Config change and illegal value:
   - Set curr_nfft 10→9 at wr_ptr=300. The current frame is still 1024 beats; the next frame is 512.
   - curr_nfft=3 gives a 1024-beat frame.
6. Reset mid-SEND: drop rstn at beat 40 of 128.
   - All outputs go to 0 immediately.
   - After release, the first burst is a fresh 128-sample frame; no stray tlast.
